pwm_dimmer_multi: RTL and testbench
===================================

Name: pwm_dimmer_multi

Overview:
Parametrised multi-channel PWM LED dimmer. It succeeds the single-channel 4-bit pwm_top.
- One shared period counter, driven by a clock prescaler, serves CHANNELS independent duty comparators.
- Duty updates are double-buffered and take effect only at period boundaries, so outputs are glitch-free.
- An optional per-channel fade mode ramps the applied duty toward its target by one step per period.
- Sits between the register/control logic and the LED pins.

Parameters:
WIDTH, 8, duty/counter width; period = 2^WIDTH-1 ticks (MAX = 2^WIDTH-1).
CHANNELS, 4, number of independent PWM outputs.
PRESCALE, 1, clk cycles per counter tick (>=1; 1 = tick every cycle).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
enable  in  1  run/stop for the whole block.
duty_in  in  CHANNELS*WIDTH  target duty per channel; channel i at [i*WIDTH +: WIDTH].
fade_en  in  CHANNELS  per-channel fade mode select.
pwm  out  CHANNELS  PWM outputs, registered.
period_start  out  1  one-cycle pulse when the period counter wraps to 0.
duty_cur  out  CHANNELS*WIDTH  currently applied duty per channel.

Behaviour:
- Reset (rst_n=0 at clk edge): pre=0, cnt=0, duty_cur=0, pwm=0, period_start=0. Applies immediately mid-period; the current period is truncated.
- Prescaler: pre counts 0..PRESCALE-1 while enable=1; tick = enable && pre==PRESCALE-1.
- Period counter: on tick, cnt increments 0..MAX-1 and wraps to 0. wrap = tick && cnt==MAX-1.
- Boundary update (on wrap), per channel i:
  - fade_en[i]=0: duty_cur[i] <= duty_in[i].
  - fade_en[i]=1: duty_cur[i] steps by 1 toward duty_in[i]; holds when equal. No overflow or underflow.
- duty_in and fade_en are sampled only at wrap. Changes mid-period have no effect on the current period.
- Output rule: pwm[i] is a register loaded from next-state values. In every cycle it equals (enable && cnt < duty_cur[i]) for the registered cnt/duty_cur of that cycle.
  - Result: high for duty_cur[i] ticks per period.
  - duty 0 gives constant 0.
  - duty MAX gives constant 1, with no low glitch at wrap.
- period_start = 1 exactly in the cycle where cnt==0 following a wrap. It does not pulse on reset exit or enable rise.
- enable=0: pre and cnt forced to 0 next edge; pwm=0 next edge; duty_cur holds; period_start=0. On enable re-assert, counting restarts from cnt=0, and the first duty update occurs at the first wrap.
- Simultaneous rst_n=0 and any other input: reset wins.
- All arithmetic unsigned, WIDTH bits. Comparison is cnt < duty_cur with both operands WIDTH wide.
- Elaboration errors: WIDTH<2, CHANNELS<1, PRESCALE<1.

Decomposition:
- Package pwm_dimmer_pkg: function/constant for MAX (2^WIDTH-1), a prescaler width helper (clog2 of PRESCALE, minimum 1), and a channel-slice index helper.
- Sub-module pwm_dimmer_channel, instantiated CHANNELS times via generate. Contains:
  - duty_cur register with fade step logic;
  - registered comparator output.
- Top level owns the prescaler, period counter, wrap and period_start.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with enable=1 and duty_in all 0xFF. Required: pwm=0, duty_cur=0, period_start=0 throughout; first wrap 255 cycles after release (WIDTH=8, PRESCALE=1).
2. Basic duty: WIDTH=4, PRESCALE=1, ch0 duty_in=3, fade_en=0, enable=1. Required: period_start every 15 cycles; from the second period on, pwm[0] is high exactly 3 of each 15 cycles, starting at cnt=0.
3. Extremes: ch1 duty=0, ch2 duty=15. Required: pwm[1] constantly 0 and pwm[2] constantly 1 across at least 3 wraps, with no single-cycle glitch.
4. Mid-period change: duty 3 to 7 applied at cnt=5. Required: current period stays 3 high; the next period is 7 high; duty_cur changes exactly one cycle after wrap.
5. Fade: duty_cur=0, target 5, fade_en=1. Required: duty_cur reads 1,2,3,4,5 after successive wraps, then holds. Retarget to 2: duty_cur reads 4,3,2, then holds.
6. Prescale/stop: PRESCALE=4, WIDTH=4, duty 3. Required: period 60 cycles, pwm high 12 cycles. Drop enable at cnt=2: pwm=0 next cycle, cnt=0. Re-enable: period_start first pulses 60 cycles later.

Source files
------------

// File: rtl/pwm_dimmer_pkg.sv
// pwm_dimmer_pkg: sizing helpers shared by the
// multi-channel PWM dimmer and its channel slices.
package pwm_dimmer_pkg;

  function automatic int max_cnt(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int pre_w(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

  function automatic int ch_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/pwm_dimmer_multi_if.sv
// pwm_dimmer_multi_if: control inputs and PWM
// outputs of the multi-channel dimmer.
interface pwm_dimmer_multi_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      enable;
  logic [CHANNELS*WIDTH-1:0] duty_in;
  logic [CHANNELS-1:0]       fade_en;
  logic [CHANNELS-1:0]       pwm;
  logic                      period_start;
  logic [CHANNELS*WIDTH-1:0] duty_cur;

  modport master (
    output enable, duty_in, fade_en,
    input  pwm, period_start, duty_cur
  );

  modport slave (
    input  enable, duty_in, fade_en,
    output pwm, period_start, duty_cur
  );
endinterface

// File: rtl/pwm_dimmer_channel.sv
// pwm_dimmer_channel: double-buffered duty with
// optional fade, plus registered comparator.
module pwm_dimmer_channel #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             wrap,
  input  logic [WIDTH-1:0] cnt_nx,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             fade_en,
  output logic [WIDTH-1:0] duty_cur,
  output logic             pwm
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] duty_nx;
  logic             up;
  logic             dn;

  assign up = fade_en && (duty_cur < duty_in);
  assign dn = fade_en && (duty_cur > duty_in);

  always_comb begin
    duty_nx = duty_cur;
    if (wrap) begin
      unique case (1'b1)
        !fade_en: duty_nx = duty_in;
        up:       duty_nx = duty_cur + ONE;
        dn:       duty_nx = duty_cur - ONE;
        default:  duty_nx = duty_cur;
      endcase
    end
  end

  // compare against next-state values so MAX never drops low at wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_cur <= '0;
      pwm      <= 1'b0;
    end else begin
      duty_cur <= duty_nx;
      pwm      <= enable && (cnt_nx < duty_nx);
    end
  end
endmodule

// File: rtl/pwm_dimmer_multi.sv
// pwm_dimmer_multi: shared prescaler and period
// counter driving CHANNELS PWM comparators.
module pwm_dimmer_multi
  import pwm_dimmer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1
) (
  input logic               clk,
  input logic               rst_n,
  pwm_dimmer_multi_if.slave bus
);
  localparam int PW = pre_w(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [WIDTH-1:0] CNT_LAST =
    WIDTH'(max_cnt(WIDTH) - 1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  if (WIDTH < 2) begin : g_bad_width
    $error("pwm_dimmer_multi: WIDTH must be >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("pwm_dimmer_multi: CHANNELS must be >= 1");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("pwm_dimmer_multi: PRESCALE must be >= 1");
  end

  logic [PW-1:0]             pre;
  logic [PW-1:0]             pre_nx;
  logic [WIDTH-1:0]          cnt;
  logic [WIDTH-1:0]          cnt_nx;
  logic                      tick;
  logic                      wrap;
  logic                      step;
  logic                      period_start;
  logic [CHANNELS-1:0]       pwm;
  logic [CHANNELS*WIDTH-1:0] duty_cur;

  assign tick = bus.enable && (pre == PRE_LAST);
  assign wrap = tick && (cnt == CNT_LAST);
  assign step = tick && !wrap;

  always_comb begin
    pre_nx = '0;
    cnt_nx = cnt;
    unique case (1'b1)
      !bus.enable: cnt_nx = '0;
      wrap:        cnt_nx = '0;
      step:        cnt_nx = cnt + CNT_ONE;
      default:     pre_nx = pre + PRE_ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre          <= pre_nx;
      cnt          <= cnt_nx;
      period_start <= wrap;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_dimmer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (bus.enable),
      .wrap     (wrap),
      .cnt_nx   (cnt_nx),
      .duty_in  (bus.duty_in[ch_lsb(i, WIDTH) +: WIDTH]),
      .fade_en  (bus.fade_en[i]),
      .duty_cur (duty_cur[ch_lsb(i, WIDTH) +: WIDTH]),
      .pwm      (pwm[i])
    );
  end

  assign bus.pwm          = pwm;
  assign bus.duty_cur     = duty_cur;
  assign bus.period_start = period_start;
endmodule

// File: tb/tb_pwm_dimmer_multi.sv
// tb_pwm_dimmer_multi: scoreboard bench over three
// dimmer configurations sharing one clock.
module tb_pwm_dimmer_multi;

  typedef struct packed {
    logic [31:0]     prev;
    logic [31:0]     dc;
    logic [15:0]     len;
    logic [3:0][8:0] hi;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic r_q   = 1'b0;
  int   tests = 0;
  int   fails = 0;

  exp_t        q8[$];
  exp_t        q4[$];
  exp_t        qp[$];
  int          cyc[3];
  int          hic[3][4];
  logic [31:0] prv[3];

  pwm_dimmer_multi_if #(.WIDTH(8), .CHANNELS(4)) b8 ();
  pwm_dimmer_multi_if #(.WIDTH(4), .CHANNELS(4)) b4 ();
  pwm_dimmer_multi_if #(.WIDTH(4), .CHANNELS(4)) bp ();

  pwm_dimmer_multi #(
    .WIDTH(8), .CHANNELS(4), .PRESCALE(1)
  ) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  pwm_dimmer_multi #(
    .WIDTH(4), .CHANNELS(4), .PRESCALE(1)
  ) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  pwm_dimmer_multi #(
    .WIDTH(4), .CHANNELS(4), .PRESCALE(4)
  ) up (.clk(clk), .rst_n(rst_n), .bus(bp));

  always #5 clk = ~clk;

  always @(posedge clk) r_q <= rst_n;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, req);
    end
  endfunction

  function automatic exp_t mk(input logic [31:0] prev,
                              input logic [31:0] dc,
                              input int len,
                              input int h3, input int h2,
                              input int h1, input int h0);
    exp_t e;
    e.prev  = prev;
    e.dc    = dc;
    e.len   = 16'(len);
    e.hi[3] = 9'(h3);
    e.hi[2] = 9'(h2);
    e.hi[1] = 9'(h1);
    e.hi[0] = 9'(h0);
    return e;
  endfunction

  function automatic bit pop(input int id, output exp_t e);
    e = '0;
    case (id)
      0: if (q8.size() > 0) begin e = q8.pop_front(); return 1'b1; end
      1: if (q4.size() > 0) begin e = q4.pop_front(); return 1'b1; end
      default:
        if (qp.size() > 0) begin e = qp.pop_front(); return 1'b1; end
    endcase
    return 1'b0;
  endfunction

  function automatic logic ps_of(input int id);
    case (id)
      0:       return b8.period_start;
      1:       return b4.period_start;
      default: return bp.period_start;
    endcase
  endfunction

  // per-period monitor: counts cycles and high ticks
  function automatic void mon(input int id, input int w,
                              input logic ps,
                              input logic [3:0] p,
                              input logic [31:0] d);
    exp_t        e;
    logic [31:0] m;
    string       u;
    u = $sformatf("u%0d", id);
    if (!r_q) begin
      chk({u, " reset pwm"}, 64'(p), 64'(0));
      chk({u, " reset duty_cur"}, 64'(d), 64'(0));
      chk({u, " reset period_start"}, 64'(ps), 64'(0));
      cyc[id] = 0;
      for (int c = 0; c < 4; c++) hic[id][c] = 0;
    end else begin
      cyc[id]++;
      if (ps) begin
        if (!pop(id, e)) begin
          tests++;
          fails++;
          $display("FAIL %s unexpected period_start: got 1, expected none", u);
        end else begin
          chk({u, " period length"}, 64'(cyc[id]), 64'(e.len));
          chk({u, " duty_cur before wrap"}, 64'(prv[id]), 64'(e.prev));
          chk({u, " duty_cur after wrap"}, 64'(d), 64'(e.dc));
          m = (32'd1 << w) - 32'd1;
          for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s ch%0d high ticks", u, c),
                64'(hic[id][c]), 64'(e.hi[c]));
            chk($sformatf("%s ch%0d pwm at cnt0", u, c),
                64'(p[c]), 64'(((e.dc >> (c * w)) & m) != 0));
          end
        end
        cyc[id] = 0;
        for (int c = 0; c < 4; c++) hic[id][c] = int'(p[c]);
      end else begin
        for (int c = 0; c < 4; c++) hic[id][c] += int'(p[c]);
      end
    end
    prv[id] = d;
  endfunction

  always @(negedge clk) begin
    mon(0, 8, b8.period_start, b8.pwm, b8.duty_cur);
    mon(1, 4, b4.period_start, b4.pwm, 32'(b4.duty_cur));
    mon(2, 4, bp.period_start, bp.pwm, 32'(bp.duty_cur));
  end

  task automatic wait_ps(input int id, input int lim);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < lim) begin
      @(negedge clk);
      n++;
      hit = ps_of(id);
    end
    if (!hit) begin
      tests++;
      fails++;
      $display("FAIL u%0d wait period_start: none within %0d cycles", id, lim);
    end
  endtask

  function automatic logic [31:0] fd(input int v);
    return 32'h0F07 | (32'(v) << 12);
  endfunction

  task automatic run_u8();
    wait_ps(0, 300);
    wait_ps(0, 300);
    b8.enable = 1'b0;
  endtask

  task automatic run_u4();
    repeat (4) wait_ps(1, 20);
    repeat (5) @(negedge clk);
    b4.duty_in[3:0] = 4'd7;
    q4.push_back(mk(32'h0F03, 32'h0F07, 15, 0, 15, 0, 3));
    q4.push_back(mk(32'h0F07, 32'h0F07, 15, 0, 15, 0, 7));
    repeat (2) wait_ps(1, 20);
    b4.fade_en[3]     = 1'b1;
    b4.duty_in[15:12] = 4'd5;
    for (int v = 1; v <= 5; v++)
      q4.push_back(mk(fd(v - 1), fd(v), 15, v - 1, 15, 0, 7));
    q4.push_back(mk(fd(5), fd(5), 15, 5, 15, 0, 7));
    repeat (6) wait_ps(1, 20);
    b4.duty_in[15:12] = 4'd2;
    for (int v = 4; v >= 2; v--)
      q4.push_back(mk(fd(v + 1), fd(v), 15, v + 1, 15, 0, 7));
    q4.push_back(mk(fd(2), fd(2), 15, 2, 15, 0, 7));
    repeat (4) wait_ps(1, 20);
    b4.enable = 1'b0;
  endtask

  task automatic run_up();
    repeat (2) wait_ps(2, 80);
    repeat (8) @(negedge clk);
    bp.enable = 1'b0;
    @(negedge clk);
    chk("u2 stop pwm", 64'(bp.pwm), 64'(0));
    chk("u2 stop duty_cur hold", 64'(bp.duty_cur), 64'(3));
    chk("u2 stop period_start", 64'(bp.period_start), 64'(0));
    repeat (9) @(negedge clk);
    bp.enable = 1'b1;
    repeat (2) wait_ps(2, 80);
    bp.enable = 1'b0;
  endtask

  initial begin
    b8.enable  = 1'b1;
    b8.duty_in = '1;
    b8.fade_en = '0;
    b4.enable  = 1'b1;
    b4.duty_in = 16'h0F03;
    b4.fade_en = '0;
    bp.enable  = 1'b1;
    bp.duty_in = 16'h0003;
    bp.fade_en = '0;

    q8.push_back(mk(32'h0, 32'hFFFF_FFFF, 255, 0, 0, 0, 0));
    q8.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 255,
                    255, 255, 255, 255));
    q4.push_back(mk(32'h0, 32'h0F03, 15, 0, 0, 0, 0));
    repeat (3)
      q4.push_back(mk(32'h0F03, 32'h0F03, 15, 0, 15, 0, 3));
    qp.push_back(mk(32'h0, 32'h3, 60, 0, 0, 0, 0));
    qp.push_back(mk(32'h3, 32'h3, 60, 0, 0, 0, 12));
    qp.push_back(mk(32'h3, 32'h3, 78, 0, 0, 0, 20));
    qp.push_back(mk(32'h3, 32'h3, 60, 0, 0, 0, 12));

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    fork
      run_u8();
      run_u4();
      run_up();
    join

    repeat (3) @(negedge clk);
    chk("u0 leftover expectations", 64'(q8.size()), 64'(0));
    chk("u1 leftover expectations", 64'(q4.size()), 64'(0));
    chk("u2 leftover expectations", 64'(qp.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
